// File: rtl/ser_defs.sv
// rtl/ser_defs.sv - shared serializer state encodings and sizing helper
package ser_defs;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    // Bits needed to hold a bit index 0..width-1 (at least one bit).
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_serializer_tx_bit_counter.sv
// rtl/piso_serializer_tx_bit_counter.sv - bit index counter with clear, enable and terminal count
module bit_counter #(
    parameter int CNT_W    = 3,
    parameter int TERMINAL = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TERMINAL);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear wins over enable so a new word always starts at index 0.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    // Register the index; reset returns it to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/piso_serializer_tx.sv
// rtl/piso_serializer_tx.sv - parallel-in serial-out transmitter with valid/ready handshakes
module piso_serializer_tx
    import ser_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last
);

    localparam int CNT_W = cnt_width(WIDTH);

    ser_state_t       state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             out_bit;
    logic             cnt_tc;
    logic             accept;
    logic             xfer;
    logic             last_xfer;

    assign accept    = load_valid && (state_q == ST_IDLE);
    assign xfer      = (state_q == ST_SHIFT) && ser_ready;
    assign last_xfer = xfer && cnt_tc;

    // Shift one position toward whichever end drives ser_data.
    always_comb begin
        shreg_d = shreg_q;
        out_bit = 1'b0;
        if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            out_bit = shreg_q[WIDTH-1];
        end else begin
            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
            out_bit = shreg_q[0];
        end
    end

    // The last transfer clears the index instead of stepping it, so it never wraps.
    bit_counter #(
        .CNT_W    (CNT_W),
        .TERMINAL (WIDTH - 1)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept || last_xfer),
        .en_i  (xfer && !cnt_tc),
        .tc_o  (cnt_tc)
    );

    // Two-state FSM owning the shift register; reset overrides accept and transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (load_valid) begin
                        shreg_q <= load_data;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ser_ready) begin
                        shreg_q <= shreg_d;
                        if (cnt_tc) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; nothing flows from inputs.
    assign load_ready = (state_q == ST_IDLE);
    assign ser_valid  = (state_q == ST_SHIFT);
    assign ser_data   = ser_valid && out_bit;
    assign ser_last   = ser_valid && cnt_tc;

endmodule

// File: tb/tb_piso_serializer_tx.sv
// tb/tb_piso_serializer_tx.sv - directed and randomized bench for piso_serializer_tx
module tb_piso_serializer_tx;

    logic       clk;
    logic       rst_n;
    logic       lv [3];
    logic [7:0] ld [3];
    logic       sr [3];
    logic       lr [3];
    logic       sv [3];
    logic       sd [3];
    logic       sl [3];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    piso_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut_m8 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]),
        .load_data(ld[0]), .ser_valid(sv[0]), .ser_ready(sr[0]),
        .ser_data(sd[0]), .ser_last(sl[0]));

    piso_serializer_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_dut_l8 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]),
        .load_data(ld[1]), .ser_valid(sv[1]), .ser_ready(sr[1]),
        .ser_data(sd[1]), .ser_last(sl[1]));

    piso_serializer_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_dut_m4 (
        .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_ready(lr[2]),
        .load_data(ld[2][3:0]), .ser_valid(sv[2]), .ser_ready(sr[2]),
        .ser_data(sd[2]), .ser_last(sl[2]));

    function automatic int wid(input int d);
        return (d == 2) ? 4 : 8;
    endfunction

    function automatic bit msbf(input int d);
        return (d != 1);
    endfunction

    // Reference: bit k of a word in transmission order.
    function automatic logic ref_bit(input int d, input logic [7:0] word, input int k);
        int idx;
        idx = msbf(d) ? (wid(d) - 1 - k) : k;
        return word[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int d, input string tag);
        chk({tag, "_load_ready"}, 32'(lr[d]), 32'd1);
        chk({tag, "_ser_valid"},  32'(sv[d]), 32'd0);
        chk({tag, "_ser_data"},   32'(sd[d]), 32'd0);
        chk({tag, "_ser_last"},   32'(sl[d]), 32'd0);
    endtask

    // mode: 0 always ready, 1 random ready, 2 toggling ready, 3 three-cycle stall after 2nd bit.
    // Called and returns at a falling edge.
    task automatic run_word(input int d, input logic [7:0] word, input int mode,
                            input bit hold_next, input logic [7:0] next_word,
                            input int abort_at, input int exp_cycles);
        int   w;
        int   k;
        int   cyc;
        int   stalled;
        logic r;
        w = wid(d);
        chk_idle(d, "pre_accept");
        lv[d] = 1'b1;
        ld[d] = word;
        @(posedge clk);
        @(negedge clk);
        lv[d] = hold_next;
        ld[d] = hold_next ? next_word : 8'($urandom);
        k = 0;
        cyc = 0;
        stalled = 0;
        while (k < w && cyc < 200) begin
            if (abort_at >= 0 && k == abort_at) begin
                rst_n = 1'b0;
                sr[d] = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                sr[d] = 1'b0;
                lv[d] = 1'b0;
                chk_idle(d, "after_abort");
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 3) != 0);
                2:       r = cyc[0];
                default: begin
                    r = !(k == 2 && stalled < 3);
                    if (!r) stalled++;
                end
            endcase
            chk("shift_ser_valid",  32'(sv[d]), 32'd1);
            chk("shift_load_ready", 32'(lr[d]), 32'd0);
            chk("shift_ser_data",   32'(sd[d]), 32'(ref_bit(d, word, k)));
            chk("shift_ser_last",   32'(sl[d]), 32'(k == w - 1));
            sr[d] = r;
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (r) k++;
        end
        if (k < w) chk("word_timeout", 32'(k), 32'(w));
        sr[d] = 1'b0;
        chk_idle(d, "post_word");
        if (exp_cycles > 0) chk("word_cycles", 32'(cyc), 32'(exp_cycles));
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lv[i] = 1'b0;
            ld[i] = 8'h00;
            sr[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_word(0, 8'h1E, 0, 1'b0, 8'h00, -1, 8);
        run_word(1, 8'h1E, 0, 1'b0, 8'h00, -1, 8);
        run_word(0, 8'hA5, 3, 1'b0, 8'h00, -1, 11);
        run_word(0, 8'h00, 0, 1'b1, 8'hFF, -1, 8);
        run_word(0, 8'hFF, 0, 1'b0, 8'h00, -1, 8);
        run_word(0, 8'hF0, 0, 1'b0, 8'h00, 3, 0);
        run_word(0, 8'h81, 0, 1'b0, 8'h00, -1, 8);
        run_word(2, 8'h09, 2, 1'b0, 8'h00, -1, 8);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 20; n++) begin
                logic [7:0] word;
                int gap;
                word = 8'($urandom);
                if (wid(d) == 4) word[7:4] = 4'h0;
                run_word(d, word, 1, 1'b0, 8'h00, -1, 0);
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++) begin
                    ld[d] = 8'($urandom);
                    @(posedge clk);
                    @(negedge clk);
                    chk_idle(d, "gap");
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piso_serializer_tx.md
PISO_SERIALIZER_TX -- requirements
Module: piso_serializer_tx

Interface
REQ-001 Parameter WIDTH, default 8, number of bits in the parallel word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 transmitted first, 0 = bit 0 transmitted first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 load_valid  input  1  parallel word offered on load_data.
REQ-006 load_ready  output  1  block able to accept a word this cycle.
REQ-007 load_data  input  WIDTH  parallel word, sampled only on accept.
REQ-008 ser_valid  output  1  ser_data carries a valid bit.
REQ-009 ser_ready  input  1  downstream consumes the current bit this cycle.
REQ-010 ser_data  output  1  current serial bit.
REQ-011 ser_last  output  1  current bit is the final bit of the word.

Function
REQ-012 States SHALL be IDLE and SHIFT only.
REQ-013 In IDLE: load_ready=1, ser_valid=0, ser_data=0, ser_last=0.
REQ-014 Accept = load_valid && load_ready at a rising edge. On accept, load_data SHALL be captured into the shift register, the bit counter SHALL be cleared to 0, and the state SHALL go to SHIFT.
REQ-015 In SHIFT: load_ready=0; load_valid SHALL be ignored and the captured word SHALL NOT change.
REQ-016 In SHIFT: ser_valid=1, and ser_data SHALL be the shift-register bit selected by MSB_FIRST.
REQ-017 A bit transfer is ser_valid && ser_ready at a rising edge; on each transfer the register SHALL shift by one position toward the output end and the counter SHALL increment.
REQ-018 When ser_ready=0, ser_data, ser_last, the counter and the shift register SHALL hold, with no limit on stall length.
REQ-019 ser_last SHALL equal 1 exactly when state is SHIFT and the counter equals WIDTH-1.
REQ-020 A transfer while ser_last=1 SHALL return the state to IDLE, so load_ready is 1 in the following cycle.
REQ-021 Latency: the first bit SHALL be valid in the cycle after accept.
REQ-022 Minimum period per word SHALL be WIDTH+1 cycles: WIDTH bit cycles plus one IDLE cycle.
REQ-023 All outputs SHALL be functions of registered state only; there SHALL be no combinational path from any input to any output.
REQ-024 The counter SHALL be wide enough to hold WIDTH-1 and SHALL never wrap within a word.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL enter IDLE and clear the counter and shift register, taking priority over accept and transfer.
REQ-026 Reset during SHIFT SHALL abort the word; the remaining bits are discarded and ser_valid=0 from the next cycle.
REQ-027 The values after reset SHALL be: load_ready=1, ser_valid=0, ser_data=0, ser_last=0.

Structure
REQ-028 State encodings (IDLE=1'b0, SHIFT=1'b1) SHALL live in the shared header/package ser_defs, for reuse by the matching receiver.
REQ-029 The bit counter SHALL be a sub-module, bit_counter, with synchronous clear, enable and terminal-count output; the FSM and shift register SHALL stay in the top module.

Verification
REQ-030 Cover: WIDTH=8, MSB_FIRST=1, load 8'h1E, ser_ready=1 -> ser_data 0,0,0,1,1,1,1,0 on 8 consecutive cycles; ser_last only on the 8th; load_ready=1 on the 9th.
REQ-031 Cover: MSB_FIRST=0, load 8'h1E -> ser_data 0,1,1,1,1,0,0,0; ser_last on the 8th bit.
REQ-032 Cover: MSB_FIRST=1, load 8'hA5, ser_ready=0 for 3 cycles after the 2nd bit -> ser_data holds 1 during the stall; the sequence is still 1,0,1,0,0,1,0,1; the word completes in 11 cycles.
REQ-033 Cover: load_valid=1 held with 8'hFF during the SHIFT of 8'h00 -> all 8 bits are 0; 8'hFF is accepted only after returning to IDLE.
REQ-034 Cover: rst_n=0 for 1 cycle after the 3rd bit of 8'hF0 -> next cycle ser_valid=0 and load_ready=1; a new load of 8'h81 then serializes 1,0,0,0,0,0,0,1.
REQ-035 Cover: WIDTH=4, load 4'b1001, ser_ready toggled every cycle -> bits 1,0,0,1 each held until accepted; ser_last on the 4th bit.
